// File: rtl/ws2812_pixel_ser.sv
// Serializes 24-bit colour words MSB-first into the WS2812 bit encoder, then holds a latch gap per frame.
// Build option: define WS2812_RGB_TO_GRB_EN to reorder incoming {R,G,B} words to {G,R,B} on the wire.
module ws2812_pixel_ser (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        pixel_valid_in,
   input  logic [23:0] pixel_data_in,
   input  logic        pixel_last_in,
   output logic        pixel_ready_out,
   input  logic [15:0] rst_cnt_in,
   input  logic        bit_done_in,
   output logic        bit_rdy_out,
   output logic        bit_data_out,
   output logic        busy_out,
   output logic        frame_done_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [23:0] hold_data_reg, hold_data_next;
   logic        hold_last_reg, hold_last_next;
   logic        hold_vld_reg, hold_vld_next;
   logic [23:0] sh_reg, sh_next;
   logic        sh_last_reg, sh_last_next;
   logic [4:0]  bit_idx_reg, bit_idx_next;
   logic [15:0] gap_cnt_reg, gap_cnt_next;
   logic [23:0] load_word;
   logic        accept;
   logic        reload;

`ifdef WS2812_RGB_TO_GRB_EN
   genvar gi;
   for (gi = 0; gi < 8; gi++) begin : g_grb
      assign load_word[gi + 16] = hold_data_reg[gi + 8];
      assign load_word[gi + 8]  = hold_data_reg[gi + 16];
      assign load_word[gi]      = hold_data_reg[gi];
   end
`else
   assign load_word = hold_data_reg;
`endif

   assign accept = pixel_valid_in & ~hold_vld_reg;

   // Holding register: an accept always wins over the reload that drains it.
   always_comb begin
      hold_data_next = hold_data_reg;
      hold_last_next = hold_last_reg;
      hold_vld_next  = hold_vld_reg;
      if (reload) begin
         hold_vld_next = 1'b0;
      end
      if (accept) begin
         hold_data_next = pixel_data_in;
         hold_last_next = pixel_last_in;
         hold_vld_next  = 1'b1;
      end
   end

   always_comb begin
      state_next   = state_reg;
      sh_next      = sh_reg;
      sh_last_next = sh_last_reg;
      bit_idx_next = bit_idx_reg;
      gap_cnt_next = gap_cnt_reg;
      reload       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (hold_vld_reg) begin
               reload       = 1'b1;
               sh_next      = load_word;
               sh_last_next = hold_last_reg;
               bit_idx_next = 5'd0;
               state_next   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (bit_done_in) begin
               if (bit_idx_reg < 5'd23) begin
                  sh_next      = {sh_reg[22:0], 1'b0};
                  bit_idx_next = bit_idx_reg + 5'd1;
                  state_next   = ST_ISSUE;
               end else if (!sh_last_reg) begin
                  // Buffered word continues the frame with no idle cycle in between.
                  if (hold_vld_reg) begin
                     reload       = 1'b1;
                     sh_next      = load_word;
                     sh_last_next = hold_last_reg;
                     bit_idx_next = 5'd0;
                     state_next   = ST_ISSUE;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  gap_cnt_next = rst_cnt_in;
                  state_next   = ST_LATCH;
               end
            end
         end
         ST_LATCH: begin
            if (gap_cnt_reg == 16'd0) begin
               state_next = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg - 16'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_reg     <= ST_IDLE;
         hold_data_reg <= 24'd0;
         hold_last_reg <= 1'b0;
         hold_vld_reg  <= 1'b0;
         sh_reg        <= 24'd0;
         sh_last_reg   <= 1'b0;
         bit_idx_reg   <= 5'd0;
         gap_cnt_reg   <= 16'd0;
      end else begin
         state_reg     <= state_next;
         hold_data_reg <= hold_data_next;
         hold_last_reg <= hold_last_next;
         hold_vld_reg  <= hold_vld_next;
         sh_reg        <= sh_next;
         sh_last_reg   <= sh_last_next;
         bit_idx_reg   <= bit_idx_next;
         gap_cnt_reg   <= gap_cnt_next;
      end
   end

   // Every output decodes registers only, so ready never depends on valid.
   assign pixel_ready_out = ~hold_vld_reg;
   assign bit_rdy_out     = (state_reg == ST_ISSUE);
   assign bit_data_out    = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) & sh_reg[23];
   assign busy_out        = (state_reg != ST_IDLE);
   assign frame_done_out  = (state_reg == ST_LATCH) && (gap_cnt_reg == 16'd0);

endmodule

// File: tb/tb_ws2812_pixel_ser.sv
// Bench for ws2812_pixel_ser: queue-based model of wire bit order, encoder responder and gap timing.
module tb_ws2812_pixel_ser;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        pixel_valid_in;
   logic [23:0] pixel_data_in;
   logic        pixel_last_in;
   logic        pixel_ready_out;
   logic [15:0] rst_cnt_in;
   logic        bit_done_in;
   logic        bit_rdy_out;
   logic        bit_data_out;
   logic        busy_out;
   logic        frame_done_out;

   always #5 clk_in = ~clk_in;

   ws2812_pixel_ser dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .pixel_valid_in  (pixel_valid_in),
      .pixel_data_in   (pixel_data_in),
      .pixel_last_in   (pixel_last_in),
      .pixel_ready_out (pixel_ready_out),
      .rst_cnt_in      (rst_cnt_in),
      .bit_done_in     (bit_done_in),
      .bit_rdy_out     (bit_rdy_out),
      .bit_data_out    (bit_data_out),
      .busy_out        (busy_out),
      .frame_done_out  (frame_done_out)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   logic [23:0] feed_data_q[$];
   bit          feed_last_q[$];
   bit          exp_bit_q[$];
   bit          exp_end_q[$];
   bit          enc_active = 0;
   bit          cur_bit = 0;
   bit          cur_end = 0;
   int          rdy_cyc = 0;
   int          enc_delay = 5;
   int          next_rdy_cyc = -1;
   int          exp_fd_cyc = -1;
   int          rdy_count = 0;
   int          frame_cnt = 0;
   logic [23:0] rx_word = 24'd0;
   bit          valid_rand = 0;
   bit          spur_latch = 0;

   function automatic logic [23:0] wire_order(input logic [23:0] w);
`ifdef WS2812_RGB_TO_GRB_EN
      return {w[15:8], w[23:16], w[7:0]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   task automatic push_pixel(input logic [23:0] w, input bit last);
      feed_data_q.push_back(w);
      feed_last_q.push_back(last);
   endtask

   // One clock: bookkeeping for the accept at the edge, bit monitor, encoder responder, feeder.
   task automatic tick();
      bit          acc;
      bit          busy_pre;
      logic [23:0] w;
      logic [23:0] wo;
      bit          l;
      acc      = pixel_valid_in && pixel_ready_out && rst_n_in;
      busy_pre = busy_out;
      @(posedge clk_in);
      #1;
      cyc++;
      bit_done_in = 1'b0;

      if (acc) begin
         w  = feed_data_q.pop_front();
         l  = feed_last_q.pop_front();
         wo = wire_order(w);
         if (!busy_pre) next_rdy_cyc = cyc + 1;
         for (int i = 23; i >= 0; i--) begin
            exp_bit_q.push_back(wo[i]);
            exp_end_q.push_back(l && (i == 0));
         end
         chk("ready_low_after_accept", 32'(pixel_ready_out), 32'(1'b0));
         $display("accept data=%06h last=%0d cycle=%0d", w, l, cyc - 1);
      end

      if (cyc == next_rdy_cyc) chk("rdy_latency", 32'(bit_rdy_out), 32'(1'b1));

      if (bit_rdy_out) begin
         if (exp_bit_q.size() == 0 || enc_active) begin
            chk("unexpected_rdy", 32'(bit_rdy_out), 32'(1'b0));
         end else begin
            cur_bit = exp_bit_q.pop_front();
            cur_end = exp_end_q.pop_front();
            chk("bit_value", 32'(bit_data_out), 32'(cur_bit));
            rx_word    = {rx_word[22:0], bit_data_out};
            rdy_count++;
            enc_active = 1;
            rdy_cyc    = cyc;
         end
      end else if (enc_active) begin
         chk("bit_hold", 32'(bit_data_out), 32'(cur_bit));
         if (cyc == rdy_cyc + enc_delay) begin
            bit_done_in = 1'b1;
            enc_active  = 0;
            if (cur_end) exp_fd_cyc = cyc + 1 + int'(rst_cnt_in);
            else if (exp_bit_q.size() > 0) next_rdy_cyc = cyc + 1;
         end
      end

      chk("frame_done", 32'(frame_done_out), 32'(cyc == exp_fd_cyc));
      if (cyc == exp_fd_cyc) begin
         chk("latch_busy", 32'(busy_out), 32'(1'b1));
         chk("latch_line_low", 32'(bit_data_out), 32'(1'b0));
         frame_cnt++;
         $display("frame %0d done cycle=%0d", frame_cnt, cyc);
      end

      if (spur_latch && exp_fd_cyc >= 0 && cyc == exp_fd_cyc - 3) begin
         bit_done_in = 1'b1;
         spur_latch  = 0;
      end

      pixel_valid_in = (feed_data_q.size() > 0) && (!valid_rand || ($urandom_range(0, 2) != 0));
      pixel_data_in  = (feed_data_q.size() > 0) ? feed_data_q[0] : 24'($urandom);
      pixel_last_in  = (feed_data_q.size() > 0) ? feed_last_q[0] : 1'b0;
   endtask

   task automatic do_reset();
      rst_n_in       = 1'b0;
      pixel_valid_in = 1'b0;
      bit_done_in    = 1'b0;
      @(posedge clk_in);
      #1;
      cyc++;
      feed_data_q.delete();
      feed_last_q.delete();
      exp_bit_q.delete();
      exp_end_q.delete();
      enc_active   = 0;
      next_rdy_cyc = -1;
      exp_fd_cyc   = -1;
      spur_latch   = 0;
      chk("rst_ready", 32'(pixel_ready_out), 32'(1'b1));
      chk("rst_busy", 32'(busy_out), 32'(1'b0));
      chk("rst_bit_rdy", 32'(bit_rdy_out), 32'(1'b0));
      chk("rst_bit_data", 32'(bit_data_out), 32'(1'b0));
      chk("rst_frame_done", 32'(frame_done_out), 32'(1'b0));
      $display("reset applied cycle=%0d", cyc);
      rst_n_in = 1'b1;
   endtask

   task automatic wait_done(input int budget, input string tag);
      bit done;
      done = 0;
      for (int k = 0; k < budget && !done; k++) begin
         tick();
         done = (feed_data_q.size() == 0) && (exp_bit_q.size() == 0) && !enc_active &&
                (cyc > exp_fd_cyc) && !busy_out;
      end
      vectors++;
      assert (done) else begin
         miscompares++;
         $error("FAIL %s: timeout, observed busy=%0b expected idle within %0d cycles", tag, busy_out, budget);
      end
   endtask

   initial begin
      logic [23:0] w;
      logic [23:0] want_w;
      bit          hit;
      int          npx;
      rst_n_in       = 1'b0;
      pixel_valid_in = 1'b0;
      pixel_data_in  = 24'd0;
      pixel_last_in  = 1'b0;
      rst_cnt_in     = 16'd0;
      bit_done_in    = 1'b0;

      do_reset();
      tick();

      // Single pixel A5_00_FF, 10-cycle gap, encoder 5 cycles
      enc_delay = 5; rst_cnt_in = 16'd10; rx_word = 24'd0; rdy_count = 0;
      push_pixel(24'hA500FF, 1'b1);
      wait_done(2000, "single_pixel");
`ifdef WS2812_RGB_TO_GRB_EN
      want_w = 24'h00A5FF;
`else
      want_w = 24'hA500FF;
`endif
      chk("single_pixel_wire", 32'(rx_word), 32'(want_w));
      chk("single_pixel_bits", 32'(rdy_count), 32'd24);

      // Zero-length latch gap
      enc_delay = 2; rst_cnt_in = 16'd0; rx_word = 24'd0;
      w = 24'($urandom);
      push_pixel(w, 1'b1);
      wait_done(1000, "zero_gap");
      chk("zero_gap_wire", 32'(rx_word), 32'(wire_order(w)));

      // Three back-to-back pixels, valid held high
      enc_delay = 3; rst_cnt_in = 16'd4; rdy_count = 0; valid_rand = 0;
      push_pixel(24'($urandom), 1'b0);
      push_pixel(24'($urandom), 1'b0);
      w = 24'($urandom);
      push_pixel(w, 1'b1);
      wait_done(3000, "back_to_back");
      chk("back_to_back_bits", 32'(rdy_count), 32'd72);
      chk("back_to_back_last_wire", 32'(rx_word), 32'(wire_order(w)));

      // Byte order 11_22_33
      enc_delay = 1; rst_cnt_in = 16'd2; rx_word = 24'd0;
      push_pixel(24'h112233, 1'b1);
      wait_done(1000, "byte_order");
`ifdef WS2812_RGB_TO_GRB_EN
      want_w = 24'h221133;
`else
      want_w = 24'h112233;
`endif
      chk("byte_order_wire", 32'(rx_word), 32'(want_w));

      // Spurious bit_done while idle
      bit_done_in = 1'b1;
      tick();
      chk("spur_idle_busy", 32'(busy_out), 32'(1'b0));
      chk("spur_idle_rdy", 32'(bit_rdy_out), 32'(1'b0));
      tick();
      chk("spur_idle_rdy2", 32'(bit_rdy_out), 32'(1'b0));

      // Spurious bit_done during the latch gap
      enc_delay = 2; rst_cnt_in = 16'd8; rx_word = 24'd0; spur_latch = 1;
      w = 24'($urandom);
      push_pixel(w, 1'b1);
      wait_done(1000, "spur_latch");
      chk("spur_latch_wire", 32'(rx_word), 32'(wire_order(w)));

      // Reset in the middle of the latch gap
      enc_delay = 1; rst_cnt_in = 16'd20;
      push_pixel(24'($urandom), 1'b1);
      hit = 0;
      for (int k = 0; k < 1000 && !hit; k++) begin
         tick();
         hit = (exp_fd_cyc >= 0) && (cyc == exp_fd_cyc - 8);
      end
      chk("mid_gap_reached", 32'(busy_out), 32'(1'b1));
      do_reset();
      tick();
      rx_word = 24'd0;
      w = 24'($urandom);
      push_pixel(w, 1'b1);
      wait_done(1000, "after_gap_reset");
      chk("after_gap_reset_wire", 32'(rx_word), 32'(wire_order(w)));

      // Reset in the middle of bit 12
      enc_delay = 5; rst_cnt_in = 16'd3; rdy_count = 0;
      push_pixel(24'($urandom), 1'b1);
      hit = 0;
      for (int k = 0; k < 2000 && !hit; k++) begin
         tick();
         hit = (rdy_count == 13) && enc_active && (cyc == rdy_cyc + 2);
      end
      chk("mid_bit_reached", 32'(rdy_count), 32'd13);
      do_reset();
      tick();
      rx_word = 24'd0; rdy_count = 0;
      w = 24'($urandom);
      push_pixel(w, 1'b1);
      wait_done(1000, "after_bit_reset");
      chk("after_bit_reset_wire", 32'(rx_word), 32'(wire_order(w)));
      chk("after_bit_reset_bits", 32'(rdy_count), 32'd24);

      // Randomized frames: pixel count, encoder delay, gap and valid throttling
      for (int f = 0; f < 8; f++) begin
         enc_delay  = int'($urandom_range(1, 6));
         rst_cnt_in = 16'($urandom_range(0, 12));
         valid_rand = bit'($urandom_range(0, 1));
         npx        = int'($urandom_range(1, 4));
         rdy_count  = 0;
         for (int p = 0; p < npx; p++) push_pixel(24'($urandom), p == npx - 1);
         wait_done(5000, "random_frame");
         chk("random_frame_bits", 32'(rdy_count), 32'(24 * npx));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
